// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcodes, frame lengths, FSM states and frame construction for the SPI RAM sequencer.
package spi_ram_pkg;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_WRMR   = 8'h01;
    localparam logic [7:0] DATA_PAGE = 8'hFF;
    localparam logic [7:0] MODE_BYTE = 8'h40;
    localparam logic [5:0] LEN_WRMR  = 6'd16;
    localparam logic [5:0] LEN_DATA  = 6'd32;
    localparam logic [5:0] LEN_FETCH = 6'd40;
    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_SHIFT, ST_TAIL, ST_DONE} state_t;
    typedef enum logic [1:0] {OWN_INIT, OWN_FETCH, OWN_DRD, OWN_DWR} owner_t;
    // Frames are left-aligned in 40 bits; bits past the frame length are never shifted out.
    function automatic logic [39:0] build_frame(owner_t o, logic [15:0] addr, logic [7:0] wd);
        return o == OWN_INIT ? {OP_WRMR, MODE_BYTE, 24'h0} :
               o == OWN_DWR  ? {OP_WRITE, addr, wd, 8'h0} : {OP_READ, addr, 16'h0};
    endfunction
    function automatic logic [5:0] frame_len(owner_t o);
        return o == OWN_INIT ? LEN_WRMR : o == OWN_FETCH ? LEN_FETCH : LEN_DATA;
    endfunction
endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: mode-0 bit engine, two cycles per bit, MISO sampled the cycle after each sck high.
module spi_shift_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [39:0] frame,
    input  logic [5:0]  nbits,
    input  logic        miso,
    output logic        cs,
    output logic        sck,
    output logic        mosi,
    output logic        last,
    output logic        done,
    output logic [15:0] rx_next
);
    logic        active, ph, samp;
    logic [5:0]  cnt;
    logic [39:0] tx;
    logic [14:0] rx;
    assign last    = active & ph & (cnt == 6'd0);
    assign rx_next = {rx, miso};
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            ph     <= 1'b0;
            samp   <= 1'b0;
            cnt    <= 6'd0;
            tx     <= 40'h0;
            rx     <= 15'h0;
            cs     <= 1'b1;
            sck    <= 1'b0;
            mosi   <= 1'b0;
            done   <= 1'b0;
        end else begin
            samp <= active & ph;
            done <= last;
            if (samp) rx <= rx_next[14:0];
            if (start) begin
                active <= 1'b1;
                ph     <= 1'b0;
                cnt    <= nbits - 6'd1;
                tx     <= {frame[38:0], 1'b0};
                mosi   <= frame[39];
                cs     <= 1'b0;
                sck    <= 1'b0;
            end else if (active && !ph) begin
                sck <= 1'b1;
                ph  <= 1'b1;
            end else if (active) begin
                sck <= 1'b0;
                ph  <= 1'b0;
                if (cnt == 6'd0) active <= 1'b0;
                else begin
                    cnt  <= cnt - 6'd1;
                    mosi <= tx[39];
                    tx   <= {tx[38:0], 1'b0};
                end
            end else if (done) cs <= 1'b1;
        end
    end
endmodule

// File: rtl/spi_ram_sequencer.sv
// spi_ram_sequencer: owns the SPI RAM bus, writes the mode register after reset,
// then serves data (priority) and fetch requests one complete frame at a time.
module spi_ram_sequencer
    import spi_ram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    output logic [15:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [7:0]  d_addr,
    input  logic [7:0]  d_wdata,
    output logic        d_ack,
    output logic [7:0]  d_rdata,
    output logic        busy,
    output logic        init_done,
    output logic        spi_cs,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    state_t      state, state_n;
    owner_t      owner, owner_n, own_sel;
    logic        start, last, eng_done, unused_ok;
    logic [15:0] addr_sel, rx_next;
    logic [39:0] frame;
    logic [5:0]  nbits;
    assign unused_ok = f_addr[15];
    assign own_sel   = d_req ? (d_we ? OWN_DWR : OWN_DRD) : OWN_FETCH;
    assign addr_sel  = d_req ? {DATA_PAGE, d_addr} : {f_addr[14:0], 1'b0};
    assign frame     = build_frame(owner_n, addr_sel, d_wdata);
    assign nbits     = frame_len(owner_n);
    always_comb begin
        state_n = state;
        owner_n = owner;
        start   = 1'b0;
        case (state)
            ST_INIT: begin
                start   = 1'b1;
                owner_n = OWN_INIT;
                state_n = ST_SHIFT;
            end
            ST_IDLE: if (d_req || f_req) begin
                start   = 1'b1;
                owner_n = own_sel;
                state_n = ST_SHIFT;
            end
            ST_SHIFT: state_n = last ? ST_TAIL : ST_SHIFT;
            ST_TAIL:  state_n = ST_DONE;
            default:  state_n = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            owner     <= OWN_INIT;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            f_rdata   <= 16'h0;
            d_rdata   <= 8'h0;
            busy      <= 1'b1;
            init_done <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            busy  <= state_n != ST_IDLE;
            f_ack <= eng_done && owner == OWN_FETCH;
            d_ack <= eng_done && (owner == OWN_DRD || owner == OWN_DWR);
            if (eng_done && owner == OWN_FETCH) f_rdata <= rx_next;
            if (eng_done && owner == OWN_DRD) d_rdata <= rx_next[7:0];
            if (eng_done && owner == OWN_INIT) init_done <= 1'b1;
        end
    end
    spi_shift_engine u_eng (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .frame   (frame),
        .nbits   (nbits),
        .miso    (spi_miso),
        .cs      (spi_cs),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .last    (last),
        .done    (eng_done),
        .rx_next (rx_next)
    );
endmodule

// File: tb/tb_spi_ram_sequencer.sv
// tb_spi_ram_sequencer: directed vectors against a behavioural SPI RAM model.
module tb_spi_ram_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] f_addr = 16'h0;
    logic [7:0]  d_addr = 8'h0, d_wdata = 8'h0;
    logic        f_ack, d_ack, busy, init_done, spi_cs, spi_sck, spi_mosi;
    logic        spi_miso = 1'b0;
    logic [15:0] f_rdata;
    logic [7:0]  d_rdata;
    int tests = 0, fails = 0;

    spi_ram_sequencer dut (
        .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .d_rdata(d_rdata), .busy(busy), .init_done(init_done), .spi_cs(spi_cs),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    // RAM model: captures mosi while sck is high, answers reads one bit per sck high
    logic [7:0]  mem [0:65535];
    logic [63:0] cap = 64'h0, last_frame = 64'h0, nc;
    logic [7:0]  mop = 8'h0, mb;
    logic [15:0] maddr = 16'h0;
    int nbit = 0, last_len = 0, fa_cnt = 0, da_cnt = 0, both_cnt = 0, cs_run = 0, last_gap = 0;
    always @(negedge clk) begin
        if (f_ack) fa_cnt++;
        if (d_ack) da_cnt++;
        if (f_ack && d_ack) both_cnt++;
        if (spi_cs) cs_run++;
        else begin
            if (cs_run > 0) last_gap = cs_run;
            cs_run = 0;
        end
        if (spi_cs) begin
            if (nbit != 0) begin
                last_frame = cap;
                last_len   = nbit;
            end
            nbit = 0;
            cap = 64'h0;
            spi_miso = 1'b0;
        end else if (spi_sck) begin
            nc = {cap[62:0], spi_mosi};
            cap = nc;
            if (nbit == 7) mop = nc[7:0];
            if (nbit == 23) maddr = nc[15:0];
            if (nbit == 31 && mop == 8'h02) mem[maddr] = nc[7:0];
            if (nbit >= 24 && mop == 8'h03) begin
                mb = mem[maddr + 16'((nbit - 24) / 8)];
                spi_miso = mb[7 - (nbit - 24) % 8];
            end else spi_miso = 1'b0;
            nbit++;
        end
    end

    typedef struct {
        logic        d;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [23:0] hdr;
        int          len;
        int          lat;
        logic [15:0] ef;
        logic [7:0]  ed;
    } vec_t;
    vec_t v[7];

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] hdr_of();
        logic [63:0] sh;
        sh = last_frame >> (last_len - 24);
        return sh[23:0];
    endfunction

    task automatic wait_idle;
        for (int i = 0; i < 300 && busy; i++) step();
    endtask

    task automatic wait_ack(input logic dport, output int n);
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (dport ? d_ack : f_ack) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input int k, input vec_t t);
        int n, fa0, da0;
        wait_idle();
        fa0 = fa_cnt;
        da0 = da_cnt;
        if (t.d) begin
            d_req = 1'b1; d_we = t.we; d_addr = t.addr[7:0]; d_wdata = t.wd;
        end else begin
            f_req = 1'b1; f_addr = t.addr;
        end
        wait_ack(t.d, n);
        d_req = 1'b0;
        f_req = 1'b0;
        check($sformatf("v%0d latency", k), n, t.lat);
        check($sformatf("v%0d frame_len", k), last_len, t.len);
        check($sformatf("v%0d header", k), {8'h0, hdr_of()}, {8'h0, t.hdr});
        if (t.d && t.we) check($sformatf("v%0d wbyte", k), {24'h0, last_frame[7:0]}, {24'h0, t.wd});
        check($sformatf("v%0d f_rdata", k), {16'h0, f_rdata}, {16'h0, t.ef});
        check($sformatf("v%0d d_rdata", k), {24'h0, d_rdata}, {24'h0, t.ed});
        step();
        check($sformatf("v%0d own_acks", k), t.d ? da_cnt - da0 : fa_cnt - fa0, 1);
        check($sformatf("v%0d other_acks", k), t.d ? fa_cnt - fa0 : da_cnt - da0, 0);
    endtask

    initial begin
        int n, fa0, da0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0024] = 8'hAB; mem[16'h0025] = 8'hCD;
        mem[16'h0002] = 8'h12; mem[16'h0003] = 8'h34;
        mem[16'hFFFF] = 8'hC3;
        v[0] = '{1'b0, 1'b0, 16'h0012, 8'h00, 24'h030024, 40, 82, 16'hABCD, 8'h00};
        v[1] = '{1'b1, 1'b1, 16'h0005, 8'h5A, 24'h02FF05, 32, 66, 16'hABCD, 8'h00};
        v[2] = '{1'b1, 1'b0, 16'h0005, 8'h00, 24'h03FF05, 32, 66, 16'hABCD, 8'h5A};
        v[3] = '{1'b0, 1'b0, 16'h8001, 8'h00, 24'h030002, 40, 82, 16'h1234, 8'h5A};
        v[4] = '{1'b1, 1'b0, 16'h00FF, 8'h00, 24'h03FFFF, 32, 66, 16'h1234, 8'hC3};
        v[5] = '{1'b1, 1'b1, 16'h0000, 8'hA5, 24'h02FF00, 32, 66, 16'h1234, 8'hC3};
        v[6] = '{1'b1, 1'b0, 16'h0000, 8'h00, 24'h03FF00, 32, 66, 16'h1234, 8'hA5};

        repeat (3) step();
        check("rst cs", spi_cs, 1);
        check("rst sck", spi_sck, 0);
        check("rst mosi", spi_mosi, 0);
        check("rst acks", {f_ack, d_ack}, 0);
        check("rst f_rdata", f_rdata, 0);
        check("rst d_rdata", d_rdata, 0);
        check("rst busy", busy, 1);
        check("rst init_done", init_done, 0);

        rst = 1'b0;
        repeat (33) step();
        check("init_done@33", init_done, 0);
        step();
        check("init_done@34", init_done, 1);
        check("init frame_len", last_len, 16);
        check("init frame", last_frame[15:0], 16'h0140);
        step();
        check("init idle busy", busy, 0);
        check("init idle cs", spi_cs, 1);
        check("init acks", fa_cnt + da_cnt, 0);

        for (int k = 0; k < 7; k++) run_vec(k, v[k]);

        // simultaneous requests: data first, fetch granted in the following idle cycle
        wait_idle();
        fa0 = fa_cnt;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05;
        f_req = 1'b1; f_addr = 16'h0012;
        wait_ack(1'b1, n);
        d_req = 1'b0;
        check("sim d latency", n, 66);
        check("sim d_rdata", d_rdata, 8'h5A);
        check("sim no f_ack yet", fa_cnt - fa0, 0);
        wait_ack(1'b0, n);
        f_req = 1'b0;
        check("sim f latency", n, 83);
        check("sim f_rdata", f_rdata, 16'hABCD);
        check("sim header", hdr_of(), 24'h030024);
        check("sim coincide", both_cnt, 0);

        // reset in the middle of a fetch; pending request completes after the repeated init
        wait_idle();
        fa0 = fa_cnt;
        f_req = 1'b1; f_addr = 16'h8001;
        repeat (40) step();
        rst = 1'b1;
        step();
        check("midrst cs", spi_cs, 1);
        check("midrst sck", spi_sck, 0);
        check("midrst f_ack", f_ack, 0);
        check("midrst init_done", init_done, 0);
        check("midrst f_rdata", f_rdata, 0);
        rst = 1'b0;
        wait_ack(1'b0, n);
        f_req = 1'b0;
        check("midrst latency", n, 117);
        check("midrst f_rdata after", f_rdata, 16'h1234);
        check("midrst header", hdr_of(), 24'h030002);
        check("midrst init_done after", init_done, 1);
        step();
        check("midrst f_ack count", fa_cnt - fa0, 1);

        // back-to-back fetches with f_req held
        wait_idle();
        fa0 = fa_cnt;
        f_req = 1'b1; f_addr = 16'h0012;
        wait_ack(1'b0, n);
        check("b2b first latency", n, 82);
        wait_ack(1'b0, n);
        f_req = 1'b0;
        check("b2b second latency", n, 83);
        check("b2b cs gap", last_gap, 2);
        check("b2b f_rdata", f_rdata, 16'hABCD);
        step();
        check("b2b f_ack count", fa_cnt - fa0, 2);
        repeat (5) step();
        check("b2b settled idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_ram_sequencer.md
# spi_ram_sequencer

Single owner of the external SPI RAM bus on uio[3:0], shared by two requesters: the instruction-fetch port (16-bit words for the program counter path) and a data port (byte load/store for data memory). The block sends a one-time mode-register write after reset. It then grants the bus to one requester at a time and runs complete READ/WRITE transactions in SPI mode 0. Returned data is delivered with a one-cycle acknowledge.

## Interface
- DATA_PAGE, 8'hFF: high byte of the SPI address for data-port accesses.
- MODE_BYTE, 8'h40: value written to the RAM mode register at init (sequential mode).

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; level, held until f_ack
- f_addr  in  16  word address (PC); byte address = {f_addr[14:0],1'b0}
- f_ack  out  1  one-cycle pulse; f_rdata valid in the same cycle
- f_rdata  out  16  fetched word; first byte received = [15:8]
- d_req  in  1  data request; level, held until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req is high
- d_addr  in  8  byte offset; SPI address = {DATA_PAGE, d_addr}
- d_wdata  in  8  write byte
- d_ack  out  1  one-cycle pulse
- d_rdata  out  8  read byte; valid when d_ack is high, otherwise holds its last value
- busy  out  1  high from grant through DONE, and during INIT
- init_done  out  1  high after the mode write completes; sticky until rst
- spi_cs  out  1  active-low chip select
- spi_sck  out  1  serial clock
- spi_mosi  out  1  master out
- spi_miso  in  1  master in, already registered one stage upstream

## Operation
- States: INIT, IDLE, SHIFT, TAIL, DONE.
- Transaction frames, MSB first:
  - Mode write: 0x01, MODE_BYTE (16 bits).
  - Fetch: 0x03, addr[15:0], 2 data bytes (40 bits).
  - Data read: 0x03, addr, 1 byte (32 bits).
  - Data write: 0x02, addr, d_wdata (32 bits).
- After rst, the block enters INIT and sends the mode write through SHIFT, TAIL and DONE. No ack is produced. init_done rises in the DONE cycle.
- Requests are ignored until init_done is high.
- In IDLE, arbitration is fixed priority: d_req wins over f_req. The winner, its address and its write data are latched in the grant cycle.
- A transaction in progress is never preempted. A request arriving mid-transaction waits.
- A data write acks without changing f_rdata or d_rdata.
- Only the granted port's ack pulses.
- Dropping req before ack is illegal. Behaviour is unspecified and the bench must not exercise it.
- Reset mid-transaction: on the next edge, spi_cs=1, spi_sck=0, no ack is issued, and the block returns to INIT (the mode write is repeated).

## Timing
- All outputs are registered.
- Reset values: spi_cs=1, spi_sck=0, spi_mosi=0, f_ack=d_ack=0, f_rdata=0, d_rdata=0, busy=1, init_done=0.
- SHIFT, two cycles per bit:
  - Phase 0: sck=0, mosi = the next bit.
  - Phase 1: sck=1.
- MISO sampling: spi_miso is sampled in the cycle after each phase 1 (this accounts for the upstream register). The last bit is therefore captured in TAIL (sck=0, cs still 0).
- Cycle numbering uses the grant cycle as 0:
  - spi_cs falls at cycle 1.
  - SHIFT runs cycles 1..2B, where B is the frame length in bits.
  - TAIL is cycle 2B+1.
  - DONE is cycle 2B+2: cs=1, ack=1, data valid.
- Latency from grant: fetch ack at cycle 82; data read/write ack at cycle 66.
- IDLE lasts at least one cycle between frames, so cs is high for at least 2 cycles (DONE + IDLE).
- A request held high during the ack cycle is taken as a new request in the following IDLE cycle.

## Structure
- Package spi_ram_pkg:
  - Opcodes: OP_READ=8'h03, OP_WRITE=8'h02, OP_WRMR=8'h01.
  - Frame lengths: 16, 32 and 40 bits.
  - State enum.
- Sub-module spi_shift_engine handles the bit/phase counter, the 40-bit TX shift register, the RX shift register and the sck/mosi/cs drive. It is loaded with the frame and bit count, and signals done at TAIL.
- Arbitration and port bookkeeping stay in the top of this block.

## Test plan
- Reset then idle: cs stays high, first frame is 0x01,0x40 on mosi (16 bits). init_done=1 at cycle 34 after rst deasserts. No ack pulses.
- Fetch f_addr=0x0012, RAM model returns 0xAB,0xCD: mosi carries 0x03,0x00,0x24. f_ack is a single pulse at cycle 82 with f_rdata=0xABCD.
- Data write d_addr=0x05, d_wdata=0x5A, DATA_PAGE=0xFF: frame is 0x02,0xFF,0x05,0x5A. d_ack at cycle 66. A subsequent read of 0x05 returns d_rdata=0x5A.
- Simultaneous d_req (read) and f_req in the same IDLE cycle: the data frame goes first with d_ack at cycle 66. The fetch is granted in the next IDLE cycle. f_ack never coincides with d_ack.
- rst asserted at cycle 40 of a fetch: the next edge shows cs=1, sck=0, and no f_ack. INIT repeats, and the still-pending f_req completes normally afterwards.
- Back-to-back fetches with f_req held high: cs is high for exactly 2 cycles between frames, and two distinct f_ack pulses occur.
